// File: rtl/pipeline_ctrl_pkg.sv
// Purpose: shared types and constants for the pipeline hazard/stall controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pipeline_ctrl_pkg;

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      MEM_WAIT = 2'd1,
      HALT     = 2'd2
   } ctrl_state_t;

   // Architectural zero register: reads as zero, writes are discarded.
   localparam logic [4:0] XZR = 5'd31;

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Purpose: bundles the pipeline-side inputs and the enable/flush outputs of pipeline_ctrl.
// Latency: n/a (wiring only).
// Backpressure: n/a; the master modport is the pipeline side, the slave modport is the controller.
interface pipeline_ctrl_if #(
   parameter int CNT_W = 32
);
   logic [4:0]       ifid_rn;
   logic [4:0]       ifid_rm;
   logic             ifid_uses_rm;
   logic [4:0]       idex_rd;
   logic             idex_memread;
   logic             branch_taken;
   logic             mem_req;
   logic             mem_ready;
   logic             pc_en;
   logic             ifid_en;
   logic             idex_en;
   logic             exmem_en;
   logic             memwr_en;
   logic             ifid_flush;
   logic             idex_bubble;
   logic [CNT_W-1:0] stall_count;
   logic             err;

   modport master (
      output ifid_rn, ifid_rm, ifid_uses_rm, idex_rd, idex_memread,
             branch_taken, mem_req, mem_ready,
      input  pc_en, ifid_en, idex_en, exmem_en, memwr_en,
             ifid_flush, idex_bubble, stall_count, err
   );

   modport slave (
      input  ifid_rn, ifid_rm, ifid_uses_rm, idex_rd, idex_memread,
             branch_taken, mem_req, mem_ready,
      output pc_en, ifid_en, idex_en, exmem_en, memwr_en,
             ifid_flush, idex_bubble, stall_count, err
   );
endinterface

// File: rtl/pipeline_ctrl_hazard_detect.sv
// Purpose: load-use comparator between the load in ID/EX and the source fields in IF/ID.
// Latency: combinational.
// Backpressure: none.
// Ports: idex_memread_i/idex_rd_i (producer), ifid_rn_i/ifid_rm_i/ifid_uses_rm_i (consumer), hazard_o.
module hazard_detect
   import pipeline_ctrl_pkg::*;
(
   input  logic       idex_memread_i,
   input  logic [4:0] idex_rd_i,
   input  logic [4:0] ifid_rn_i,
   input  logic [4:0] ifid_rm_i,
   input  logic       ifid_uses_rm_i,
   output logic       hazard_o
);

   logic rn_match;
   logic rm_match;

   assign rn_match = (idex_rd_i == ifid_rn_i);
   assign rm_match = ifid_uses_rm_i && (idex_rd_i == ifid_rm_i);

   // A load into XZR produces no value, so nothing can depend on it.
   assign hazard_o = idex_memread_i && (idex_rd_i != XZR) && (rn_match || rm_match);

endmodule

// File: rtl/pipeline_ctrl.sv
// Purpose: pipeline register enable/flush controller: memory freeze, load-use stall, branch flush.
// Latency: outputs combinational from state and inputs; state/counters update on the next clk edge.
// Backpressure: a memory wait freezes the whole pipe; a wait longer than TIMEOUT halts until reset.
// Ports: clk, reset (sync, active-high), bus (pipeline_ctrl_if.slave).
module pipeline_ctrl
   import pipeline_ctrl_pkg::*;
#(
   parameter int TIMEOUT = 16,
   parameter int CNT_W   = 32
) (
   input  logic             clk,
   input  logic             reset,
   pipeline_ctrl_if.slave   bus
);

   localparam int WAIT_W = $clog2(TIMEOUT + 1);

   ctrl_state_t       state_q, state_d;
   logic [WAIT_W-1:0] wait_q, wait_d;
   logic [CNT_W-1:0]  stall_q, stall_d;
   logic              err_q, err_d;

   logic              hazard;
   logic              freeze;
   logic [WAIT_W-1:0] wait_inc;
   logic              pc_en;
   logic              ifid_en;
   logic              pipe_en;
   logic              flush;
   logic              bubble;

   hazard_detect u_hazard_detect (
      .idex_memread_i (bus.idex_memread),
      .idex_rd_i      (bus.idex_rd),
      .ifid_rn_i      (bus.ifid_rn),
      .ifid_rm_i      (bus.ifid_rm),
      .ifid_uses_rm_i (bus.ifid_uses_rm),
      .hazard_o       (hazard)
   );

   assign freeze   = bus.mem_req && !bus.mem_ready;
   assign wait_inc = wait_q + 1'b1;

   always_comb begin
      state_d = state_q;
      wait_d  = wait_q;
      err_d   = err_q;
      pc_en   = 1'b1;
      ifid_en = 1'b1;
      pipe_en = 1'b1;
      flush   = 1'b0;
      bubble  = 1'b0;

      case (state_q)
         RUN, MEM_WAIT: begin
            if (freeze) begin
               pc_en   = 1'b0;
               ifid_en = 1'b0;
               pipe_en = 1'b0;
               wait_d  = wait_inc;
               // The cycle that completes TIMEOUT waits is the last one tolerated.
               if (wait_inc >= WAIT_W'(TIMEOUT)) begin
                  state_d = HALT;
                  err_d   = 1'b1;
               end else begin
                  state_d = MEM_WAIT;
               end
            end else if (state_q == MEM_WAIT) begin
               // Release cycle: everything advances so the returned data is captured.
               state_d = RUN;
               wait_d  = '0;
            end else begin
               wait_d = '0;
               // Hazard masks the branch; the branch is seen again next cycle.
               if (hazard) begin
                  pc_en   = 1'b0;
                  ifid_en = 1'b0;
                  bubble  = 1'b1;
               end else if (bus.branch_taken) begin
                  flush = 1'b1;
               end
            end
         end
         HALT: begin
            pc_en   = 1'b0;
            ifid_en = 1'b0;
            pipe_en = 1'b0;
            err_d   = 1'b1;
         end
         default: begin
            state_d = RUN;
            wait_d  = '0;
         end
      endcase
   end

   // Saturating count of cycles in which the PC did not advance.
   assign stall_d = (!pc_en && (stall_q != {CNT_W{1'b1}})) ? stall_q + 1'b1 : stall_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= RUN;
         wait_q  <= '0;
         stall_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         wait_q  <= wait_d;
         stall_q <= stall_d;
         err_q   <= err_d;
      end
   end

   assign bus.pc_en       = pc_en;
   assign bus.ifid_en     = ifid_en;
   assign bus.idex_en     = pipe_en;
   assign bus.exmem_en    = pipe_en;
   assign bus.memwr_en    = pipe_en;
   assign bus.ifid_flush  = flush;
   assign bus.idex_bubble = bubble;
   assign bus.stall_count = stall_q;
   assign bus.err         = err_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Purpose: self-checking bench for pipeline_ctrl: single-cycle vector table plus multi-cycle sequences.
// Latency: n/a.
// Backpressure: n/a.
module tb_pipeline_ctrl;
   import pipeline_ctrl_pkg::*;

   localparam int TO = 16;
   localparam int CW = 5;

   typedef struct packed {
      logic       mem_req;
      logic       mem_ready;
      logic       memread;
      logic [4:0] rd;
      logic [4:0] rn;
      logic [4:0] rm;
      logic       uses_rm;
      logic       branch;
   } in_t;

   typedef struct {
      in_t        in;
      logic [6:0] exp;
      string      name;
   } vec_t;

   typedef struct {
      logic [6:0] exp;
      string      name;
   } sb_t;

   // Expected {pc, ifid, idex, exmem, memwr, flush, bubble}
   localparam logic [6:0] E_RUN = 7'b11111_00;
   localparam logic [6:0] E_LU  = 7'b00111_01;
   localparam logic [6:0] E_FRZ = 7'b00000_00;
   localparam logic [6:0] E_BR  = 7'b11111_10;

   logic clk;
   logic reset;
   int   n_cmp;
   int   n_err;
   sb_t  sb[$];
   vec_t vecs[$];

   pipeline_ctrl_if #(.CNT_W(CW)) bus ();

   pipeline_ctrl #(.TIMEOUT(TO), .CNT_W(CW)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic in_t mk(input logic req, input logic rdy, input logic mr,
                              input logic [4:0] rd, input logic [4:0] rn, input logic [4:0] rm,
                              input logic urm, input logic br);
      in_t v;
      v.mem_req = req; v.mem_ready = rdy; v.memread = mr;
      v.rd = rd; v.rn = rn; v.rm = rm; v.uses_rm = urm; v.branch = br;
      return v;
   endfunction

   function automatic logic [6:0] outs();
      return {bus.pc_en, bus.ifid_en, bus.idex_en, bus.exmem_en, bus.memwr_en,
              bus.ifid_flush, bus.idex_bubble};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic drive(input in_t v);
      bus.mem_req      = v.mem_req;
      bus.mem_ready    = v.mem_ready;
      bus.idex_memread = v.memread;
      bus.idex_rd      = v.rd;
      bus.ifid_rn      = v.rn;
      bus.ifid_rm      = v.rm;
      bus.ifid_uses_rm = v.uses_rm;
      bus.branch_taken = v.branch;
   endtask

   // Drive one cycle of inputs at the falling edge, sample outputs 2 time units later.
   task automatic step(input in_t v, input logic [6:0] exp, input string name);
      sb_t e;
      @(negedge clk);
      reset = 1'b0;
      drive(v);
      sb.push_back('{exp, name});
      #2;
      if (sb.size() == 0) begin
         n_cmp++;
         n_err++;
         $display("FAIL %s: scoreboard empty", name);
      end else begin
         e = sb.pop_front();
         chk(e.name, {25'd0, outs()}, {25'd0, e.exp});
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      drive('0);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
   endtask

   in_t idle, frz, rdy, lu1;

   initial begin
      n_cmp = 0;
      n_err = 0;
      reset = 1'b1;
      drive('0);
      idle = '0;
      frz  = mk(1, 0, 0, 0, 0, 0, 0, 0);
      rdy  = mk(1, 1, 0, 0, 0, 0, 0, 0);
      lu1  = mk(0, 0, 1, 5'd1, 5'd1, 0, 0, 0);

      vecs.push_back('{idle,                              E_RUN, "v_idle"});
      vecs.push_back('{lu1,                               E_LU,  "v_lu_rn"});
      vecs.push_back('{mk(0, 0, 1, 2, 5, 2, 1, 0),        E_LU,  "v_lu_rm"});
      vecs.push_back('{mk(0, 0, 1, 2, 5, 2, 0, 0),        E_RUN, "v_rm_unused"});
      vecs.push_back('{mk(0, 0, 1, 31, 31, 31, 1, 0),     E_RUN, "v_xzr"});
      vecs.push_back('{mk(0, 0, 0, 1, 1, 1, 1, 0),        E_RUN, "v_not_load"});
      vecs.push_back('{mk(0, 0, 0, 0, 0, 0, 0, 1),        E_BR,  "v_branch"});
      vecs.push_back('{mk(0, 0, 1, 3, 3, 0, 0, 1),        E_LU,  "v_lu_over_br"});
      vecs.push_back('{frz,                               E_FRZ, "v_freeze"});
      vecs.push_back('{mk(1, 0, 1, 3, 3, 0, 0, 1),        E_FRZ, "v_frz_over_all"});
      vecs.push_back('{mk(1, 1, 0, 0, 0, 0, 0, 1),        E_BR,  "v_ready_branch"});
      vecs.push_back('{mk(0, 1, 0, 0, 0, 0, 0, 0),        E_RUN, "v_ready_only"});

      // Reset state
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      #2;
      chk("rst_outs", {25'd0, outs()}, {25'd0, E_RUN});
      chk("rst_stall", 32'(bus.stall_count), 32'd0);
      chk("rst_err", {31'd0, bus.err}, 32'd0);

      foreach (vecs[i]) begin
         do_reset();
         step(vecs[i].in, vecs[i].exp, vecs[i].name);
      end

      // Single load-use stall, then pipe resumes.
      do_reset();
      step(lu1, E_LU, "lu_stall");
      step(idle, E_RUN, "lu_resume");
      chk("lu_stall_cnt", 32'(bus.stall_count), 32'd1);

      // XZR load never stalls.
      do_reset();
      step(mk(0, 0, 1, 31, 31, 0, 0, 0), E_RUN, "xzr_nostall");
      step(idle, E_RUN, "xzr_next");
      chk("xzr_stall_cnt", 32'(bus.stall_count), 32'd0);

      // Three-cycle memory wait then release.
      do_reset();
      for (int i = 0; i < 3; i++) step(frz, E_FRZ, "mw_freeze");
      step(rdy, E_RUN, "mw_release");
      chk("mw_stall_cnt", 32'(bus.stall_count), 32'd3);
      step(lu1, E_LU, "mw_back_in_run");
      chk("mw_err", {31'd0, bus.err}, 32'd0);

      // Timeout into HALT, counter saturation, reset out of HALT.
      do_reset();
      for (int i = 0; i < TO; i++) step(frz, E_FRZ, "to_freeze");
      chk("to_err_before", {31'd0, bus.err}, 32'd0);
      step(rdy, E_FRZ, "halt_ignores_ready");
      chk("halt_err", {31'd0, bus.err}, 32'd1);
      chk("halt_stall_cnt", 32'(bus.stall_count), 32'(TO));
      for (int i = 0; i < 20; i++) step(idle, E_FRZ, "halt_hold");
      chk("stall_saturate", 32'(bus.stall_count), 32'd31);
      do_reset();
      step(idle, E_RUN, "halt_reset_outs");
      chk("halt_reset_err", {31'd0, bus.err}, 32'd0);
      chk("halt_reset_stall", 32'(bus.stall_count), 32'd0);

      // Hazard hides branch; branch acted on next cycle only.
      do_reset();
      step(mk(0, 0, 1, 4, 4, 0, 0, 1), E_LU, "lu_br_bubble");
      step(mk(0, 0, 0, 0, 0, 0, 0, 1), E_BR, "br_after_lu");
      step(idle, E_RUN, "br_one_cycle");

      // Reset mid-MEM_WAIT (inputs still freezing), then a full fresh wait budget.
      do_reset();
      step(frz, E_FRZ, "mwr_freeze0");
      step(frz, E_FRZ, "mwr_freeze1");
      step(frz, E_FRZ, "mwr_freeze2");
      reset = 1'b1;
      step(idle, E_RUN, "mwr_after_reset");
      chk("mwr_err", {31'd0, bus.err}, 32'd0);
      chk("mwr_stall", 32'(bus.stall_count), 32'd0);
      for (int i = 0; i < TO - 1; i++) step(frz, E_FRZ, "mwr_fresh_wait");
      step(rdy, E_RUN, "mwr_fresh_release");
      chk("mwr_fresh_err", {31'd0, bus.err}, 32'd0);

      if (sb.size() != 0) begin
         n_cmp++;
         n_err++;
         $display("FAIL sb_drain: %0d left, expected 0", sb.size());
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16, meaning the maximum number of consecutive memory-wait cycles before the block halts.
REQ-002 SHALL have parameter CNT_W, default 32, meaning the width of stall_count.
REQ-003 SHALL have clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have ifid_rn  input  5  Rn field of the instruction in IF/ID.
REQ-006 SHALL have ifid_rm  input  5  Rm/Rt field of the instruction in IF/ID.
REQ-007 SHALL have ifid_uses_rm  input  1  IF/ID instruction reads ifid_rm.
REQ-008 SHALL have idex_rd  input  5  destination register held in ID/EX.
REQ-009 SHALL have idex_memread  input  1  ID/EX instruction is a load (MemToReg).
REQ-010 SHALL have branch_taken  input  1  taken branch resolved in ID this cycle.
REQ-011 SHALL have mem_req, mem_ready  input  1 each  data-memory access active in EX/MEM; data available.
REQ-012 SHALL have pc_en, ifid_en, idex_en, exmem_en, memwr_en  output  1 each  enables for the PC and the four pipeline registers.
REQ-013 SHALL have ifid_flush  output  1  IF/ID loads NOP; idex_bubble  output  1  ID/EX loads all-zero control.
REQ-014 SHALL have stall_count  output  CNT_W  count of cycles with pc_en low; err  output  1  sticky timeout flag.

Function
REQ-015 SHALL implement states RUN, MEM_WAIT, HALT.
REQ-016 Freeze condition: mem_req && !mem_ready; in RUN or MEM_WAIT, a freeze SHALL drive all five enables 0, with ifid_flush 0 and idex_bubble 0, in the same cycle.
REQ-017 A freeze in RUN SHALL transition to MEM_WAIT.
REQ-018 In MEM_WAIT, mem_ready=1 SHALL drive all enables 1 in the same cycle and transition to RUN.
REQ-019 Wait counter: SHALL increment on each freeze cycle and clear on RUN.
REQ-020 When the wait counter reaches TIMEOUT, the block SHALL enter HALT.
REQ-021 HALT: all enables 0; err=1; HALT is exited only by reset.
REQ-022 Load-use hazard: idex_memread && idex_rd!=31 && (idex_rd==ifid_rn || (ifid_uses_rm && idex_rd==ifid_rm)).
REQ-023 On a load-use hazard in RUN with no freeze: pc_en=0, ifid_en=0, idex_bubble=1; idex_en, exmem_en, memwr_en stay 1.
REQ-024 Register 31 (XZR) SHALL never cause a hazard.
REQ-025 Taken branch in RUN with no hazard and no freeze: ifid_flush=1 for that cycle only; all enables 1.
REQ-026 Priority: freeze > load-use > branch; suppressed events produce no output in that cycle and are re-evaluated on the following cycle.
REQ-027 Otherwise: all enables 1, ifid_flush=0, idex_bubble=0.
REQ-028 stall_count SHALL increment on every cycle with pc_en=0, including HALT, and saturate at all-ones.

Reset
REQ-029 On reset: state=RUN, wait counter=0, stall_count=0, err=0.
REQ-030 After reset with idle inputs: enables=1, ifid_flush=0, idex_bubble=0.
REQ-031 Reset SHALL take effect from any state, including mid-MEM_WAIT and HALT.
REQ-032 Reset SHALL override all inputs in the same cycle.

Structure
REQ-033 Shared package pipeline_ctrl_pkg SHALL hold the ctrl_state_t enum (RUN, MEM_WAIT, HALT) and the constant XZR=5'd31.
REQ-034 The load-use comparator SHALL be a combinational sub-module hazard_detect, instantiated once.
REQ-035 Outputs SHALL be a combinational function of state and inputs; only state, the wait counter, stall_count and err are registered.

Verification
REQ-036 Load X1 in ID/EX, ifid_rn=1 -> one cycle pc_en=0, ifid_en=0, idex_bubble=1; next cycle all enables 1; stall_count=1.
REQ-037 Same load with idex_rd=31, ifid_rn=31 -> no stall; stall_count=0.
REQ-038 mem_req=1, mem_ready=0 for 3 cycles, then 1 -> all enables 0 for 3 cycles, RUN on the 4th; stall_count=3.
REQ-039 mem_ready held 0 for 16 cycles (TIMEOUT=16) -> HALT, err=1, enables 0; reset -> RUN, err=0, stall_count=0.
REQ-040 Load-use and branch_taken together -> bubble, ifid_flush=0; next cycle (hazard gone, branch_taken=1) -> ifid_flush=1.
REQ-041 Reset asserted on the 2nd MEM_WAIT cycle -> RUN next cycle; a fresh freeze restarts the wait counter at 0.
